pwm_modulator: RTL
==================

Name: pwm_modulator

Overview:
- Downstream consumer of the decoder's sample stream (sample / new_sample).
- Buffers incoming 8-bit samples in a small FIFO.
- Replays them at a fixed rate as an 8-bit PWM waveform on a single output pin. Each sample is held for FRAMES_PER_SAMPLE PWM frames of 256 clocks.
- Reports FIFO fill level and flags overflow/underrun so the controller can pace the host.

Parameters:
- FIFO_DEPTH, 16, number of sample entries; power of two, minimum 4.
- FRAMES_PER_SAMPLE, 4, PWM frames (256 clocks each) per sample; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  run PWM playback when high.
- sample  input  8  sample byte from the decoder.
- new_sample  input  1  single-cycle strobe; sample is valid this cycle.
- pwm_out  output  1  registered PWM output.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of stored samples.
- overflow  output  1  one-cycle pulse when a sample is dropped because the FIFO is full.
- underrun  output  1  one-cycle pulse when a sample load finds the FIFO empty.

Behaviour:
- Reset (rst low, asynchronous):
  - pwm_out=0, fifo_level=0, overflow=0, underrun=0.
  - FIFO pointers=0, duty=0, pwm_cnt=0, frame_cnt=0.
- FIFO write:
  - On new_sample=1 with the FIFO not full, store sample at the write pointer; the pointer wraps modulo FIFO_DEPTH.
  - On new_sample=1 with the FIFO full and no pop in the same cycle, drop the sample and pulse overflow for 1 cycle.
  - Full with a simultaneous pop: the write is accepted, and fifo_level stays at FIFO_DEPTH.
  - Writes are accepted regardless of enable.
- fifo_level update is registered: +1 on write only, -1 on pop only, unchanged on both or neither.
- PWM counters:
  - pwm_cnt is 8 bits and increments every clock while enable=1, wrapping 255->0.
  - frame_cnt increments when pwm_cnt wraps, and wraps at FRAMES_PER_SAMPLE-1 -> 0.
  - enable=0: pwm_cnt, frame_cnt and pwm_out are synchronously forced to 0 and duty keeps its value.
- Sample load (tick) condition: enable=1, pwm_cnt=255 and frame_cnt=FRAMES_PER_SAMPLE-1.
  - FIFO not empty: duty <= head entry and the FIFO pops.
  - FIFO empty: duty holds its previous value and underrun pulses for 1 cycle.
  - There is no write-to-read bypass. A write in the same cycle as a tick on an empty FIFO still produces an underrun, and the written sample is stored.
  - The new duty takes effect from the next frame (pwm_cnt=0).
- PWM output:
  - pwm_out <= (pwm_cnt < duty), registered, so pwm_out lags pwm_cnt by 1 cycle.
  - duty=0 gives constant 0.
  - duty=255 gives high for 255 of 256 clocks.
  - duty=N gives exactly N high clocks per frame, contiguous at the frame start.
- Startup: after reset or an enable rise, the first frame uses the current duty (0 after reset). The first load occurs at the end of frame FRAMES_PER_SAMPLE-1.
- Sample period is 256*FRAMES_PER_SAMPLE clocks (1024 at the default).
- Reset asserted mid-operation discards all buffered samples immediately.

Test Plan:
1. Reset, enable=1, write samples 0x40 and 0xC0 before the first tick -> first 1024 clocks pwm_out=0; next 1024 clocks, 64 high clocks per frame; following 1024 clocks, 192 high clocks per frame; fifo_level goes 2->1->0 at the ticks.
2. Write 17 samples back-to-back with enable=0, FIFO_DEPTH=16 -> fifo_level=16; overflow pulses once on the 17th write; the first 16 values replay in order after enable=1.
3. Load one sample 0x80 then starve the FIFO -> underrun pulses at the second tick; pwm_out continues at 128 high clocks per frame.
4. FIFO full, new_sample coincident with a tick -> no overflow; fifo_level stays 16; the new value plays last in order.
5. Duty boundaries 0x00, 0x01, 0xFF -> 0, 1 and 255 high clocks per frame respectively, the high period starting 1 cycle after pwm_cnt=0.
6. Drop enable mid-frame, then assert rst low asynchronously between clock edges -> pwm_out=0 immediately on enable-low edge+1; on reset, fifo_level=0 with no clock needed; after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/pwm_modulator.sv
// Sample FIFO feeding an 8-bit PWM generator; each buffered sample sets the
// duty for FRAMES_PER_SAMPLE frames of 256 clocks.
module pwm_modulator #(
  parameter int FIFO_DEPTH        = 16,
  parameter int FRAMES_PER_SAMPLE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0]                    sample,
  input  logic                          new_sample,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SAMPLE - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    duty_q;
  logic [7:0]    pwm_cnt_q;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          pwm_q, ovf_q, udr_q;
  logic          full, empty, tick, pop, push;

  always_comb begin
    full  = (level_q == LEVEL_FULL);
    empty = (level_q == '0);
    tick  = enable && (pwm_cnt_q == 8'hFF) && (frame_cnt_q == FRAME_LAST);
    pop   = tick && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    push  = new_sample && (!full || pop);

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    frame_cnt_d = frame_cnt_q;
    if (pwm_cnt_q == 8'hFF) begin
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
    end
  end

  // Sample storage carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      duty_q      <= '0;
      pwm_cnt_q   <= '0;
      frame_cnt_q <= '0;
      pwm_q       <= 1'b0;
      ovf_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= new_sample && full && !pop;
      udr_q   <= tick && empty;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        duty_q   <= mem_q[rd_ptr_q];
      end
      // Disabling parks the counters at frame start; duty is retained.
      if (enable) begin
        pwm_cnt_q   <= pwm_cnt_q + 8'd1;
        frame_cnt_q <= frame_cnt_d;
        pwm_q       <= (pwm_cnt_q < duty_q);
      end else begin
        pwm_cnt_q   <= '0;
        frame_cnt_q <= '0;
        pwm_q       <= 1'b0;
      end
    end
  end

  assign pwm_out    = pwm_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underrun   = udr_q;

endmodule
